fetch_request_unit: RTL and testbench

//   Producer side of the instruction buffer. Holds the program counter and issues word

---
 rtl/apogeo_pkg.sv | 17 +
 rtl/fetch_request_tracker.sv | 81 ++++++++
 rtl/fetch_request_unit.sv | 92 +++++++++
 tb/tb_fetch_request_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/apogeo_pkg.sv
// Shared fetch-side types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apogeo_pkg;

    typedef logic [31:0] data_word_t;

    // Instruction words are 4 bytes; sequential fetch steps by one word.
    localparam data_word_t FETCH_WORD_INCR      = 32'd4;
    localparam data_word_t DEFAULT_BOOT_ADDRESS = 32'h0000_0000;

    // Next sequential word address, wrapping modulo 2^32.
    function automatic data_word_t next_word_address(input data_word_t addr);
        return addr + FETCH_WORD_INCR;
    endfunction

endpackage

// File: rtl/fetch_request_tracker.sv
// Counts fetch requests in flight and old-stream responses still to be discarded.
// Latency: counters update one cycle after issue/response; accept_o is combinational.
// Backpressure: can_issue_o drops once MAX_OUTSTANDING new-stream requests are unanswered.
module fetch_request_tracker #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic issue_i,
    input  logic flush_i,
    input  logic fetch_valid_i,
    output logic can_issue_o,
    output logic accept_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_ZERO = '0;
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_MAX  = '1;
    localparam cnt_t CNT_LIM  = cnt_t'(MAX_OUTSTANDING);

    cnt_t outstanding_q, outstanding_d;
    cnt_t discard_q, discard_d;

    logic         discarding;
    logic [CW:0]  in_flight_total;
    logic [CW:0]  old_stream_left;

    assign discarding  = (discard_q != CNT_ZERO);
    assign can_issue_o = (outstanding_q < CNT_LIM);
    // A response in a flush cycle belongs to the old stream and is never written.
    assign accept_o    = fetch_valid_i & ~discarding & ~flush_i;

    // Old-stream responses left after a flush: everything in flight minus one arriving now.
    always_comb begin
        in_flight_total = {1'b0, outstanding_q} + {1'b0, discard_q};
        old_stream_left = in_flight_total;
        if (fetch_valid_i && (in_flight_total != '0)) begin
            old_stream_left = in_flight_total - {{CW{1'b0}}, 1'b1};
        end
    end

    // Next-state for the outstanding and discard counters.
    always_comb begin
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (flush_i) begin
            // Repeated flushes can in theory stack more than the counter holds; saturate.
            if (old_stream_left > {1'b0, CNT_MAX}) begin
                discard_d = CNT_MAX;
            end else begin
                discard_d = old_stream_left[CW-1:0];
            end
            outstanding_d = issue_i ? CNT_ONE : CNT_ZERO;
        end else begin
            if (fetch_valid_i && discarding) begin
                discard_d = discard_q - CNT_ONE;
            end
            unique case ({issue_i, accept_o})
                2'b10:   outstanding_d = outstanding_q + CNT_ONE;
                2'b01:   outstanding_d = outstanding_q - CNT_ONE;
                default: outstanding_d = outstanding_q;
            endcase
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            outstanding_q <= CNT_ZERO;
            discard_q     <= CNT_ZERO;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: rtl/fetch_request_unit.sv
// Holds the PC, issues word fetches and drives the instruction buffer write strobes.
// Latency: address strobe at issue, BTB strobe +1 cycle, instruction strobe same cycle as fetch valid.
// Backpressure: no issue while buffer_full_i or the in-flight request limit is reached.
module fetch_request_unit
    import apogeo_pkg::*;
#(
    parameter data_word_t BOOT_ADDRESS    = DEFAULT_BOOT_ADDRESS,
    parameter int         MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_address_i,
    input  logic        buffer_full_i,
    output logic        fetch_request_o,
    output logic [31:0] fetch_address_o,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_instruction_i,
    input  logic        btb_hit_i,
    input  logic        btb_taken_i,
    input  logic [31:0] btb_target_i,
    output logic        write_address_o,
    output logic        write_speculative_o,
    output logic        write_instruction_o,
    output logic [31:0] buffer_address_o,
    output logic        speculative_o,
    output logic        taken_o,
    output logic [31:0] buffer_instruction_o
);

    data_word_t pc_q, pc_d;
    logic       btb_pending_q, btb_pending_d;

    logic       can_issue;
    logic       accept;
    logic       issue;
    logic       predicted_taken;
    data_word_t issue_address;

    fetch_request_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_tracker (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .issue_i       (issue),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .can_issue_o   (can_issue),
        .accept_o      (accept)
    );

    // Issue address: flush redirect beats a predicted-taken BTB result, which beats the PC.
    always_comb begin
        issue           = rst_n_i & ~buffer_full_i & can_issue;
        predicted_taken = btb_pending_q & btb_hit_i & btb_taken_i;
        if (flush_i) begin
            issue_address = redirect_address_i;
        end else if (predicted_taken) begin
            issue_address = btb_target_i;
        end else begin
            issue_address = pc_q;
        end
        // Without an issue the redirect/target is still captured so it is not lost.
        pc_d          = issue ? next_word_address(issue_address) : issue_address;
        btb_pending_d = issue;
    end

    // Buffer and fetch port strobes; all held low while reset is asserted.
    always_comb begin
        fetch_request_o      = issue;
        write_address_o      = issue;
        fetch_address_o      = issue_address;
        buffer_address_o     = issue_address;
        write_speculative_o  = rst_n_i & btb_pending_q;
        speculative_o        = rst_n_i & btb_pending_q & btb_hit_i;
        taken_o              = rst_n_i & btb_pending_q & btb_hit_i & btb_taken_i;
        write_instruction_o  = rst_n_i & accept;
        buffer_instruction_o = fetch_instruction_i;
    end

    // PC and BTB-pending registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q          <= BOOT_ADDRESS;
            btb_pending_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            btb_pending_q <= btb_pending_d;
        end
    end

endmodule

// File: tb/tb_fetch_request_unit.sv
module tb_fetch_request_unit;

    logic        clk;
    logic        rst_n_i;
    logic        flush_i;
    logic [31:0] redirect_address_i;
    logic        buffer_full_i;
    logic        fetch_request_o;
    logic [31:0] fetch_address_o;
    logic        fetch_valid_i;
    logic [31:0] fetch_instruction_i;
    logic        btb_hit_i;
    logic        btb_taken_i;
    logic [31:0] btb_target_i;
    logic        write_address_o;
    logic        write_speculative_o;
    logic        write_instruction_o;
    logic [31:0] buffer_address_o;
    logic        speculative_o;
    logic        taken_o;
    logic [31:0] buffer_instruction_o;

    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];

    fetch_request_unit #(
        .BOOT_ADDRESS    (32'h0000_0000),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i                (clk),
        .rst_n_i              (rst_n_i),
        .flush_i              (flush_i),
        .redirect_address_i   (redirect_address_i),
        .buffer_full_i        (buffer_full_i),
        .fetch_request_o      (fetch_request_o),
        .fetch_address_o      (fetch_address_o),
        .fetch_valid_i        (fetch_valid_i),
        .fetch_instruction_i  (fetch_instruction_i),
        .btb_hit_i            (btb_hit_i),
        .btb_taken_i          (btb_taken_i),
        .btb_target_i         (btb_target_i),
        .write_address_o      (write_address_o),
        .write_speculative_o  (write_speculative_o),
        .write_instruction_o  (write_instruction_o),
        .buffer_address_o     (buffer_address_o),
        .speculative_o        (speculative_o),
        .taken_o              (taken_o),
        .buffer_instruction_o (buffer_instruction_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the bench memory returns for a given address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check just after, then advance.
    task automatic step(input string tag,
                        input logic full, input logic flush, input logic [31:0] redir,
                        input logic valid, input logic [31:0] instr,
                        input logic hit, input logic taken, input logic [31:0] tgt,
                        input logic e_req, input logic [31:0] e_addr,
                        input logic e_ws, input logic e_spec, input logic e_tk,
                        input logic e_wi);
        logic [31:0] exp_word;
        buffer_full_i       = full;
        flush_i             = flush;
        redirect_address_i  = redir;
        fetch_valid_i       = valid;
        fetch_instruction_i = instr;
        btb_hit_i           = hit;
        btb_taken_i         = taken;
        btb_target_i        = tgt;
        if (e_wi) exp_q.push_back(instr);
        #1;
        chk1({tag, ".req"}, fetch_request_o, e_req);
        chk1({tag, ".wa"}, write_address_o, e_req);
        if (e_req) begin
            chk32({tag, ".addr"}, fetch_address_o, e_addr);
            chk32({tag, ".baddr"}, buffer_address_o, e_addr);
        end
        chk1({tag, ".ws"}, write_speculative_o, e_ws);
        if (e_ws) begin
            chk1({tag, ".spec"}, speculative_o, e_spec);
            chk1({tag, ".taken"}, taken_o, e_tk);
        end
        chk1({tag, ".wi"}, write_instruction_o, e_wi);
        if (write_instruction_o) begin
            if (exp_q.size() > 0) begin
                exp_word = exp_q.pop_front();
                chk32({tag, ".sb_word"}, buffer_instruction_o, exp_word);
            end else begin
                chk32({tag, ".sb_unexpected"}, buffer_instruction_o, 32'hxxxx_xxxx);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n_i             = 1'b0;
        flush_i             = 1'b0;
        redirect_address_i  = 32'h0;
        buffer_full_i       = 1'b0;
        fetch_valid_i       = 1'b1;
        fetch_instruction_i = mem_word(32'h123);
        btb_hit_i           = 1'b0;
        btb_taken_i         = 1'b0;
        btb_target_i        = 32'h0;

        // Reset: every strobe low even with a response presented.
        repeat (2) @(negedge clk);
        #1;
        chk1("rst.req", fetch_request_o, 1'b0);
        chk1("rst.wa", write_address_o, 1'b0);
        chk1("rst.ws", write_speculative_o, 1'b0);
        chk1("rst.wi", write_instruction_o, 1'b0);
        rst_n_i = 1'b1;

        //   tag    full flush redir          valid instr                hit tk tgt            req addr           ws sp tk wi
        // Back-to-back issue from boot until four requests are in flight.
        step("S1", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0000, 0, 0, 0, 0);
        step("S2", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0004, 1, 0, 0, 0);
        step("S3", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0008, 1, 0, 0, 0);
        step("S4", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_000C, 1, 0, 0, 0);
        step("S5", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          0, 32'h0,         1, 0, 0, 0);
        step("S6", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
        // Buffer full for five cycles while the four responses drain.
        step("F1", 1, 0, 32'h0,          1, mem_word(32'h0),      0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 1);
        step("F2", 1, 0, 32'h0,          1, mem_word(32'h4),      0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 1);
        step("F3", 1, 0, 32'h0,          1, mem_word(32'h8),      0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 1);
        step("F4", 1, 0, 32'h0,          1, mem_word(32'hC),      0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 1);
        step("F5", 1, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
        // Resume at the held PC, then redirect to 0x100 and take a BTB prediction to 0x200.
        step("R1", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0010, 0, 0, 0, 0);
        step("R2", 0, 1, 32'h0000_0100,  0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0100, 1, 0, 0, 0);
        step("R3", 0, 0, 32'h0,          0, 32'h0,                1, 1, 32'h0000_0200,  1, 32'h0000_0200, 1, 1, 1, 0);
        step("R4", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0204, 1, 0, 0, 0);
        step("R5", 1, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          0, 32'h0,         1, 0, 0, 0);
        step("D1", 1, 0, 32'h0,          1, mem_word(32'h10),     0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
        step("D2", 1, 0, 32'h0,          1, mem_word(32'h100),    0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 1);
        step("D3", 1, 0, 32'h0,          1, mem_word(32'h200),    0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 1);
        step("D4", 1, 0, 32'h0,          1, mem_word(32'h204),    0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 1);
        // Three in flight, flush to 0x400: three old responses dropped, fourth written.
        step("G1", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0208, 0, 0, 0, 0);
        step("G2", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_020C, 1, 0, 0, 0);
        step("G3", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0210, 1, 0, 0, 0);
        step("G4", 0, 1, 32'h0000_0400,  0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0400, 1, 0, 0, 0);
        step("G5", 1, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          0, 32'h0,         1, 0, 0, 0);
        step("G6", 1, 0, 32'h0,          1, mem_word(32'h208),    0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
        step("G7", 1, 0, 32'h0,          1, mem_word(32'h20C),    0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
        step("G8", 1, 0, 32'h0,          1, mem_word(32'h210),    0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
        step("G9", 1, 0, 32'h0,          1, mem_word(32'h400),    0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 1);
        // Flush coincident with a response, two in flight: that response and one more dropped.
        step("H1", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0404, 0, 0, 0, 0);
        step("H2", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0408, 1, 0, 0, 0);
        step("H3", 0, 1, 32'h0000_0500,  1, mem_word(32'h404),    0, 0, 32'h0,          1, 32'h0000_0500, 1, 0, 0, 0);
        step("H4", 1, 0, 32'h0,          1, mem_word(32'h408),    0, 0, 32'h0,          0, 32'h0,         1, 0, 0, 0);
        step("H5", 1, 0, 32'h0,          1, mem_word(32'h500),    0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 1);
        // Predicted-taken result while the buffer is full: target kept and issued later.
        step("P1", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0504, 0, 0, 0, 0);
        step("P2", 1, 0, 32'h0,          0, 32'h0,                1, 1, 32'h0000_0800,  0, 32'h0,         1, 1, 1, 0);
        step("P3", 1, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
        step("P4", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0800, 0, 0, 0, 0);
        step("P5", 1, 0, 32'h0,          1, mem_word(32'h504),    0, 0, 32'h0,          0, 32'h0,         1, 0, 0, 1);
        step("P6", 1, 0, 32'h0,          1, mem_word(32'h800),    0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 1);
        // Address wrap from the top word back to zero.
        step("W1", 0, 1, 32'hFFFF_FFFC,  0, 32'h0,                0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        step("W2", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0000, 1, 0, 0, 0);
        step("W3", 1, 0, 32'h0,          1, mem_word(32'hFFFF_FFFC), 0, 0, 32'h0,       0, 32'h0,         1, 0, 0, 1);
        step("W4", 1, 0, 32'h0,          1, mem_word(32'h0),      0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 1);
        // Reset in the middle of traffic restarts from the boot address.
        step("M1", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0004, 0, 0, 0, 0);
        rst_n_i = 1'b0;
        step("M2", 0, 0, 32'h0,          1, mem_word(32'h4),      0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
        step("M3", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          0, 32'h0,         0, 0, 0, 0);
        rst_n_i = 1'b1;
        step("M4", 0, 0, 32'h0,          0, 32'h0,                0, 0, 32'h0,          1, 32'h0000_0000, 0, 0, 0, 0);

        chk32("sb.leftover", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
